// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared sample width, Q1.15 saturation limits and sample type
package iir_pkg;
   localparam int SAMPLE_W = 16;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
   localparam sample_t SAT_MAX = sample_t'(16'h7FFF);
   localparam sample_t SAT_MIN = sample_t'(16'h8000);
endpackage

// File: rtl/iir_out_decimator_if.sv
// rtl/iir_out_decimator_if.sv - valid/ready output stream of the decimator
interface iir_out_decimator_if #(
   parameter int DW = iir_pkg::SAMPLE_W
);
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/iir_sync_fifo.sv
// rtl/iir_sync_fifo.sv - first-word fall-through FIFO; a full FIFO accepts a push when popped
// the same cycle, and rdata_o keeps the last popped word while empty.
module iir_sync_fifo
   import iir_pkg::*;
#(
   parameter int DW    = SAMPLE_W,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   push_i,
   input  logic [DW-1:0]          wdata_i,
   input  logic                   pop_i,
   output logic [DW-1:0]          rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic [DW-1:0] last_q;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = empty_o ? last_q : mem_q[rd_ptr_q];
   assign level_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         last_q   <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            last_q   <= mem_q[rd_ptr_q];
         end
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr) mem_q[wr_ptr_q] <= wdata_i;
   end
endmodule

// File: rtl/iir_out_decimator.sv
// rtl/iir_out_decimator.sv - boxcar decimator with rounding, saturating gain and output FIFO.
// Optional IIR_OUT_PEAK_EN adds peak_abs, the running max of |y_in|.
module iir_out_decimator
   import iir_pkg::*;
#(
   parameter int DW      = SAMPLE_W,
   parameter int DEC     = 4,
   parameter int DEPTH   = 8,
   parameter int GAIN_SH = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic [DW-1:0]          y_in,
   input  logic                   y_valid,
   iir_out_decimator_if.master    m_if,
   output logic [$clog2(DEPTH):0] level,
   output logic [15:0]            ovf_cnt,
   output logic                   sat_flag
`ifdef IIR_OUT_PEAK_EN
   ,
   output logic [DW-1:0]          peak_abs
`endif
);
   localparam int L  = $clog2(DEC);
   localparam int PW = (L > 0) ? L : 1;
   localparam int AW = DW + L;
   localparam int SW = DW + 4;
   localparam int HI = (DW == SAMPLE_W) ? int'(SAT_MAX) : (2**(DW-1)) - 1;
   localparam int LO = (DW == SAMPLE_W) ? int'(SAT_MIN) : -(2**(DW-1));
   localparam logic signed [SW-1:0] HI_V  = SW'(HI);
   localparam logic signed [SW-1:0] LO_V  = SW'(LO);
   localparam logic [DW-1:0]        MAX_V = DW'(HI);
   localparam logic [DW-1:0]        MIN_V = DW'(LO);
   localparam logic signed [AW:0]   RND   = (L == 0) ? '0 : (AW+1)'(2**(L-1));

   logic [PW-1:0]        phase_q, phase_d;
   logic signed [AW-1:0] acc_q, acc_d, acc_sum, y_ext;
   logic [DW-1:0]        stg_q, stg_d, res;
   logic                 stg_vld_q, stg_vld_d;
   logic [15:0]          ovf_q, ovf_d;
   logic                 sat_q, sat_d;
   logic signed [AW:0]   rnd;
   logic signed [DW-1:0] avg;
   logic signed [SW-1:0] shv;
   logic                 last, sat_hi, sat_lo, fifo_full, fifo_empty, drop;

   assign y_ext   = AW'($signed(y_in));
   assign acc_sum = acc_q + y_ext;
   assign last    = (phase_q == PW'(DEC-1));
   // Widen by one bit so the half-LSB rounding offset cannot wrap the block sum.
   assign rnd     = $signed({acc_sum[AW-1], acc_sum}) + RND;
   assign avg     = DW'(rnd >>> L);
   assign shv     = SW'(avg) <<< GAIN_SH;
   assign sat_hi  = (shv > HI_V);
   assign sat_lo  = (shv < LO_V);
   assign res     = sat_hi ? MAX_V : (sat_lo ? MIN_V : shv[DW-1:0]);
   assign drop    = stg_vld_q && fifo_full && !(m_if.m_valid && m_if.m_ready);

   always_comb begin
      phase_d   = phase_q;
      acc_d     = acc_q;
      stg_d     = stg_q;
      sat_d     = sat_q;
      ovf_d     = ovf_q;
      stg_vld_d = y_valid && last;
      if (y_valid) begin
         if (last) begin
            phase_d = '0;
            acc_d   = '0;
            stg_d   = res;
            sat_d   = sat_q | sat_hi | sat_lo;
         end else begin
            phase_d = phase_q + 1'b1;
            acc_d   = acc_sum;
         end
      end
      if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q   <= '0;
         acc_q     <= '0;
         stg_q     <= '0;
         stg_vld_q <= 1'b0;
         ovf_q     <= '0;
         sat_q     <= 1'b0;
      end else if (clr) begin
         phase_q   <= '0;
         acc_q     <= '0;
         stg_vld_q <= 1'b0;
         ovf_q     <= '0;
         sat_q     <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         acc_q     <= acc_d;
         stg_q     <= stg_d;
         stg_vld_q <= stg_vld_d;
         ovf_q     <= ovf_d;
         sat_q     <= sat_d;
      end
   end

   iir_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .push_i  (stg_vld_q),
      .wdata_i (stg_q),
      .pop_i   (m_if.m_ready),
      .rdata_o (m_if.m_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level)
   );

   assign m_if.m_valid = !fifo_empty;
   assign ovf_cnt      = ovf_q;
   assign sat_flag     = sat_q;

`ifdef IIR_OUT_PEAK_EN
   logic [DW-1:0] peak_q, peak_d, abs_y;

   // The most negative sample has no positive twin; clip it to full scale.
   assign abs_y = (y_in == MIN_V) ? MAX_V : (y_in[DW-1] ? (~y_in + 1'b1) : y_in);

   always_comb begin
      peak_d = peak_q;
      if (y_valid && abs_y > peak_q) peak_d = abs_y;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      peak_q <= '0;
      else if (clr) peak_q <= '0;
      else          peak_q <= peak_d;
   end

   assign peak_abs = peak_q;
`endif
endmodule

// File: tb/tb_iir_out_decimator.sv
// tb/tb_iir_out_decimator.sv - bench for iir_out_decimator (GAIN_SH=0 and GAIN_SH=1 instances)
module tb_iir_out_decimator;
   import iir_pkg::*;

   typedef struct {
      int s[4];
      bit gaps;
      int exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        y_valid = 1'b0;
   logic [15:0] y_in = '0;
   logic [3:0]  level0, level1;
   logic [15:0] ovf0, ovf1;
   logic        sat0, sat1;
`ifdef IIR_OUT_PEAK_EN
   logic [15:0] peak0, peak1;
`endif

   int checks = 0;
   int failures = 0;
   int sb0[$];
   int sb1[$];
   vec_t tbl[8];
   int blk[4];

   iir_out_decimator_if #(.DW(16)) if0 ();
   iir_out_decimator_if #(.DW(16)) if1 ();

   always #5 clk = ~clk;

   iir_out_decimator #(.DW(16), .DEC(4), .DEPTH(8), .GAIN_SH(0)) u0 (
      .clk(clk), .rst(rst), .clr(clr), .y_in(y_in), .y_valid(y_valid), .m_if(if0),
      .level(level0), .ovf_cnt(ovf0), .sat_flag(sat0)
`ifdef IIR_OUT_PEAK_EN
      , .peak_abs(peak0)
`endif
   );

   iir_out_decimator #(.DW(16), .DEC(4), .DEPTH(8), .GAIN_SH(1)) u1 (
      .clk(clk), .rst(rst), .clr(clr), .y_in(y_in), .y_valid(y_valid), .m_if(if1),
      .level(level1), .ovf_cnt(ovf1), .sat_flag(sat1)
`ifdef IIR_OUT_PEAK_EN
      , .peak_abs(peak1)
`endif
   );

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic send_sample(input int v);
      y_in = 16'(v);
      y_valid = 1'b1;
      @(posedge clk);
      #1;
      y_valid = 1'b0;
   endtask

   task automatic send_block(input int s[4], input bit gaps, input int exp0, input bit keep0);
      if (keep0) sb0.push_back(exp0);
      sb1.push_back(sat16(2 * exp0));
      for (int i = 0; i < 4; i++) begin
         send_sample(s[i]);
         if (gaps) begin
            repeat (2) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Scoreboard: compare every word the consumer accepts.
   always @(negedge clk) begin
      if (!rst) begin
         if (if0.m_valid && if0.m_ready) begin
            if (sb0.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb0_extra actual=%0d expected=none", $signed(if0.m_data));
            end else chk("sb0_data", int'($signed(if0.m_data)), sb0.pop_front());
         end
         if (if1.m_valid && if1.m_ready) begin
            if (sb1.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb1_extra actual=%0d expected=none", $signed(if1.m_data));
            end else chk("sb1_data", int'($signed(if1.m_data)), sb1.pop_front());
         end
      end
   end

   initial begin
      if0.m_ready = 1'b1;
      if1.m_ready = 1'b1;
      tbl[0] = '{'{-1, -2, -3, -4}, 1'b0, -2};
      tbl[1] = '{'{5, 5, 5, 5}, 1'b1, 5};
      tbl[2] = '{'{1, 1, 1, 2}, 1'b0, 1};
      tbl[3] = '{'{-1, -1, -1, -2}, 1'b0, -1};
      tbl[4] = '{'{1, 1, 0, 0}, 1'b0, 1};
      tbl[5] = '{'{-1, -1, 0, 0}, 1'b1, 0};
      tbl[6] = '{'{100, -50, 7, 3}, 1'b0, 15};
      tbl[7] = '{'{-100, 50, -7, -3}, 1'b0, -15};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", int'(level0), 0);
      chk("rst_valid", int'(if0.m_valid), 0);
      chk("rst_data", int'(if0.m_data), 0);
      chk("rst_ovf", int'(ovf0), 0);
      chk("rst_sat", int'(sat1), 0);
      rst = 1'b0;

      // First block: exact latency and one-cycle valid with m_ready high.
      sb0.push_back(3);
      sb1.push_back(6);
      send_sample(1);
      send_sample(2);
      send_sample(3);
      y_in = 16'd4;
      y_valid = 1'b1;
      @(posedge clk);
      #1;
      y_valid = 1'b0;
      chk("t1_valid_stage", int'(if0.m_valid), 0);
      @(posedge clk);
      #1;
      chk("t1_valid_rise", int'(if0.m_valid), 1);
      chk("t1_data", int'($signed(if0.m_data)), 3);
      chk("t1_level", int'(level0), 1);
      @(posedge clk);
      #1;
      chk("t1_valid_fall", int'(if0.m_valid), 0);

      for (int i = 0; i < 8; i++) begin
         send_block(tbl[i].s, tbl[i].gaps, tbl[i].exp, 1'b1);
         settle();
      end
      chk("nosat_u1", int'(sat1), 0);

      blk = '{20000, 20000, 20000, 20000};
      send_block(blk, 1'b0, 20000, 1'b1);
      settle();
      chk("sat_u1_set", int'(sat1), 1);
      chk("sat_u0_clear", int'(sat0), 0);
      blk = '{-20000, -20000, -20000, -20000};
      send_block(blk, 1'b0, -20000, 1'b1);
      settle();
      blk = '{32767, 32767, 32767, 32767};
      send_block(blk, 1'b0, 32767, 1'b1);
      settle();
      blk = '{-32768, -32768, -32768, -32768};
      send_block(blk, 1'b0, -32768, 1'b1);
      settle();
      chk("sat_u0_edges", int'(sat0), 0);

      // Nine blocks into a stalled FIFO: the ninth is dropped.
      if0.m_ready = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         blk = '{k, k, k, k};
         send_block(blk, 1'b0, k, k <= 8);
      end
      settle();
      chk("full_level", int'(level0), 8);
      chk("full_ovf", int'(ovf0), 1);
      chk("full_head", int'($signed(if0.m_data)), 1);
      if0.m_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("drain_level", int'(level0), 0);
      chk("drain_valid", int'(if0.m_valid), 0);
      chk("drain_hold", int'($signed(if0.m_data)), 8);
      chk("drain_sb", sb0.size(), 0);

      // Full FIFO with push and pop on the same edge.
      if0.m_ready = 1'b0;
      for (int k = 11; k <= 18; k++) begin
         blk = '{k, k, k, k};
         send_block(blk, 1'b0, k, 1'b1);
      end
      settle();
      chk("refill_level", int'(level0), 8);
      sb0.push_back(19);
      sb1.push_back(38);
      send_sample(19);
      send_sample(19);
      send_sample(19);
      y_in = 16'd19;
      y_valid = 1'b1;
      @(posedge clk);
      #1;
      y_valid = 1'b0;
      if0.m_ready = 1'b1;
      @(posedge clk);
      #1;
      if0.m_ready = 1'b0;
      chk("pushpop_level", int'(level0), 8);
      chk("pushpop_ovf", int'(ovf0), 1);

      // clr with a simultaneous sample mid-block.
      send_sample(3);
      send_sample(3);
      y_in = 16'd3;
      y_valid = 1'b1;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      y_valid = 1'b0;
      chk("clr_level", int'(level0), 0);
      chk("clr_ovf", int'(ovf0), 0);
      chk("clr_valid", int'(if0.m_valid), 0);
      chk("clr_sat", int'(sat1), 0);
      sb0.delete();
      sb1.delete();
      if0.m_ready = 1'b1;
      blk = '{4, 4, 4, 8};
      send_block(blk, 1'b0, 5, 1'b1);
      settle();

      // Asynchronous reset mid-block with a word waiting in the FIFO.
      if0.m_ready = 1'b0;
      blk = '{7, 7, 7, 7};
      send_block(blk, 1'b0, 7, 1'b0);
      settle();
      chk("prerst_level", int'(level0), 1);
      send_sample(100);
      send_sample(100);
      rst = 1'b1;
      #2;
      chk("arst_level", int'(level0), 0);
      chk("arst_valid", int'(if0.m_valid), 0);
      chk("arst_data", int'(if0.m_data), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      if0.m_ready = 1'b1;
      blk = '{8, 8, 8, 8};
      send_block(blk, 1'b0, 8, 1'b1);
      settle();
`ifdef IIR_OUT_PEAK_EN
      chk("peak_after_rst", int'(peak0), 8);
      send_sample(-32768);
      chk("peak_clip", int'(peak0), 32767);
`endif

      repeat (5) @(posedge clk);
      #1;
      chk("end_sb0", sb0.size(), 0);
      chk("end_sb1", sb1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
